// File: rtl/ov7670_threshold_capture.sv
// ov7670_threshold_capture
//   Captures OV7670 YUV422 bytes on cam_pclk, keeps the luma (Y) samples and thresholds each one
//   to a single bit. The pixel stream is forced to exactly H_PIXELS*V_LINES pixels per frame
//   (short lines/frames padded with 0, surplus pixels/lines dropped) because the downstream frame
//   buffer has no frame-sync input and only counts pixels.
//
//   Optional feature macro: THRESH_HYST_EN
//     defined   : hysteresis threshold with half-band HYST, the previous pixel's bit is kept
//                 inside the band (cleared to 0 at each line start)
//     undefined : plain compare Y >= threshold, HYST ignored
//
// Ports
//   cam_pclk     in   camera pixel clock, sole clock
//   rst          in   asynchronous reset, active-high
//   cam_vsync    in   OV7670 VSYNC, high during vertical sync
//   cam_href     in   OV7670 HREF, high while line bytes are valid
//   cam_data     in   OV7670 D[7:0]
//   threshold    in   luma threshold, quasi-static
//   invert       in   1: invert pixel_bit polarity of captured pixels
//   pixel_valid  out  one pixel this cycle
//   pixel_bit    out  thresholded pixel
//   frame_start  out  1-cycle pulse with the first pixel of a frame
//   frame_error  out  1-cycle pulse after the last pixel if a pad/truncate/overrun occurred
module ov7670_threshold_capture #(
   parameter int unsigned H_PIXELS = 320,
   parameter int unsigned V_LINES  = 240,
   parameter int unsigned Y_FIRST  = 0,
   parameter int unsigned HYST     = 8
) (
   input  logic       cam_pclk,
   input  logic       rst,
   input  logic       cam_vsync,
   input  logic       cam_href,
   input  logic [7:0] cam_data,
   input  logic [7:0] threshold,
   input  logic       invert,
   output logic       pixel_valid,
   output logic       pixel_bit,
   output logic       frame_start,
   output logic       frame_error
);

   localparam int unsigned XW = $clog2(H_PIXELS + 1);
   localparam int unsigned YW = $clog2(V_LINES + 1);
   localparam logic [XW-1:0] XLast = XW'(H_PIXELS - 1);
   localparam logic [XW-1:0] XFull = XW'(H_PIXELS);
   localparam logic [YW-1:0] YLast = YW'(V_LINES - 1);
   // Byte phase that carries Y: odd phase for U,Y,V,Y order, even phase for Y,U,Y,V.
   localparam logic YPhase = (Y_FIRST == 0);

   if (HYST > 255) begin : g_hyst_range
      $error("HYST must fit in 8 bits");
   end

   typedef enum logic [1:0] {StSync, StIdle, StLine, StPad} state_e;

   logic          s_vsync, s_vsync_prev, s_href, s_href_prev;
   logic [7:0]    s_data;
   state_e        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          pad_frame_q, pad_frame_d;
   logic          phase_q, phase_d;
   logic          err_q, err_d;
   logic          last_q;
   logic          href_rise, vsync_fall, cur_phase, is_y, raw_bit;
   logic          line_byte, emit, emit_bit, data_emit, err_evt, emit_first, emit_last;

   // Input register stage plus one-cycle history for edge detection.
   always_ff @(posedge cam_pclk or posedge rst) begin
      if (rst) begin
         s_vsync      <= 1'b0;
         s_vsync_prev <= 1'b0;
         s_href       <= 1'b0;
         s_href_prev  <= 1'b0;
         s_data       <= 8'd0;
      end else begin
         s_vsync      <= cam_vsync;
         s_vsync_prev <= s_vsync;
         s_href       <= cam_href;
         s_href_prev  <= s_href;
         s_data       <= cam_data;
      end
   end

   assign href_rise  = s_href & ~s_href_prev;
   assign vsync_fall = ~s_vsync & s_vsync_prev;
   // Phase of the byte now in s_data: 0 on the first byte of a line.
   assign cur_phase  = href_rise ? 1'b0 : phase_q;
   assign phase_d    = s_href & ~cur_phase;
   assign is_y       = s_href & (cur_phase == YPhase);

`ifdef THRESH_HYST_EN
   logic [8:0] thr_hi, thr_lo;
   logic [7:0] hi8, lo8;
   logic       hyst_q, hyst_d, prev_bit;

   always_comb begin
      thr_hi   = {1'b0, threshold} + 9'(HYST);
      thr_lo   = {1'b0, threshold} - 9'(HYST);
      hi8      = thr_hi[8] ? 8'hff : thr_hi[7:0];
      lo8      = thr_lo[8] ? 8'h00 : thr_lo[7:0];
      prev_bit = href_rise ? 1'b0 : hyst_q;
      if (s_data >= hi8) begin
         raw_bit = 1'b1;
      end else if (s_data < lo8) begin
         raw_bit = 1'b0;
      end else begin
         raw_bit = prev_bit;
      end
      // Only captured pixels feed the history; pads do not.
      hyst_d = data_emit ? raw_bit : prev_bit;
   end

   always_ff @(posedge cam_pclk or posedge rst) begin
      if (rst) begin
         hyst_q <= 1'b0;
      end else begin
         hyst_q <= hyst_d;
      end
   end
`else
   assign raw_bit = (s_data >= threshold);
`endif

   assign emit_first = (x_q == '0) && (y_q == '0);
   assign emit_last  = (x_q == XLast) && (y_q == YLast);

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      pad_frame_d = pad_frame_q;
      err_d       = err_q;
      line_byte   = 1'b0;
      emit        = 1'b0;
      emit_bit    = 1'b0;
      data_emit   = 1'b0;
      err_evt     = 1'b0;

      unique case (state_q)
         StSync: begin
            if (vsync_fall) begin
               state_d = StIdle;
               x_d     = '0;
               y_d     = '0;
               err_d   = 1'b0;
            end
         end
         StIdle: begin
            if (s_vsync) begin
               // Frame ended early: pad out the remaining lines.
               state_d     = StPad;
               pad_frame_d = 1'b1;
               err_evt     = 1'b1;
            end else if (href_rise) begin
               state_d   = StLine;
               line_byte = 1'b1;
            end
         end
         StLine: begin
            if (s_href) begin
               line_byte = 1'b1;
            end else if (x_q == XFull) begin
               x_d     = '0;
               y_d     = y_q + 1'b1;
               state_d = (y_q == YLast) ? StSync : StIdle;
            end else begin
               state_d     = StPad;
               pad_frame_d = 1'b0;
               err_evt     = 1'b1;
            end
         end
         StPad: begin
            // Padding wins over a new line; its bytes are lost.
            if (href_rise) begin
               err_evt = 1'b1;
            end
            emit = 1'b1;
            if (x_q == XLast) begin
               x_d = '0;
               y_d = y_q + 1'b1;
               if (y_q == YLast) begin
                  state_d = StSync;
               end else if (!pad_frame_q) begin
                  state_d = StIdle;
               end
            end else begin
               x_d = x_q + 1'b1;
            end
         end
         default: state_d = StSync;
      endcase

      if (line_byte && is_y) begin
         if (x_q == XFull) begin
            err_evt = 1'b1;
         end else begin
            emit      = 1'b1;
            data_emit = 1'b1;
            emit_bit  = raw_bit ^ invert;
            x_d       = x_q + 1'b1;
         end
      end

      if (err_evt) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge cam_pclk or posedge rst) begin
      if (rst) begin
         state_q     <= StSync;
         x_q         <= '0;
         y_q         <= '0;
         pad_frame_q <= 1'b0;
         phase_q     <= 1'b0;
         err_q       <= 1'b0;
         last_q      <= 1'b0;
         pixel_valid <= 1'b0;
         pixel_bit   <= 1'b0;
         frame_start <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         pad_frame_q <= pad_frame_d;
         phase_q     <= phase_d;
         err_q       <= err_d;
         last_q      <= emit & emit_last;
         pixel_valid <= emit;
         pixel_bit   <= emit & emit_bit;
         frame_start <= emit & emit_first;
         // last_q marks the cycle the final pixel is on the output.
         frame_error <= last_q & err_q;
      end
   end

endmodule

// File: tb/tb_ov7670_threshold_capture.sv
module tb_ov7670_threshold_capture;

   localparam int unsigned H = 4;
   localparam int unsigned V = 2;
   localparam int unsigned HY = 8;

   logic       cam_pclk = 1'b0;
   logic       rst;
   logic       cam_vsync, cam_href, invert;
   logic [7:0] cam_data, threshold;
   logic       pv0, pb0, fs0, fe0;
   logic       pv1, pb1, fs1, fe1;

   always #5 cam_pclk = ~cam_pclk;

   ov7670_threshold_capture #(.H_PIXELS(H), .V_LINES(V), .Y_FIRST(0), .HYST(HY)) dut0 (
      .cam_pclk(cam_pclk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
      .cam_data(cam_data), .threshold(threshold), .invert(invert),
      .pixel_valid(pv0), .pixel_bit(pb0), .frame_start(fs0), .frame_error(fe0)
   );

   ov7670_threshold_capture #(.H_PIXELS(H), .V_LINES(V), .Y_FIRST(1), .HYST(HY)) dut1 (
      .cam_pclk(cam_pclk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
      .cam_data(cam_data), .threshold(threshold), .invert(invert),
      .pixel_valid(pv1), .pixel_bit(pb1), .frame_start(fs1), .frame_error(fe1)
   );

   int checks = 0;
   int failures = 0;

   // Observed and expected streams, one entry per pixel: {frame_start, pixel_bit}.
   logic [1:0] got0[$], got1[$], exp0[$], exp1[$];
   int         gerr0 = 0, gerr1 = 0, eerr = 0;

   // Reference-model frame state.
   bit         armed = 0;
   int         line_idx = 0;
   bit         ferr = 0;
   logic [7:0] lb[0:15];

   always @(negedge cam_pclk) begin
      if (pv0) got0.push_back({fs0, pb0});
      if (pv1) got1.push_back({fs1, pb1});
      if (fe0) gerr0++;
      if (fe1) gerr1++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge cam_pclk);
   endtask

   // Luma-to-bit rule for one sample; prev is the previous captured bit of the line.
   function automatic bit ref_bit(input logic [7:0] y, input bit prev);
      int t, hi, lo;
      t = int'(threshold);
`ifdef THRESH_HYST_EN
      hi = (t + int'(HY) > 255) ? 255 : t + int'(HY);
      lo = (t - int'(HY) < 0) ? 0 : t - int'(HY);
      if (int'(y) >= hi) return 1'b1;
      if (int'(y) < lo) return 1'b0;
      return prev;
`else
      return (int'(y) >= t);
`endif
   endfunction

   // Expected pixels of one line of nby bytes for both byte orders.
   task automatic model_line(input int nby);
      int ny;
      bit prev, b;
      ny = nby / 2;
      if (line_idx < int'(V)) begin
         if (ny != int'(H)) ferr = 1;
         for (int k = 0; k < 2; k++) begin
            prev = 0;
            for (int i = 0; i < int'(H); i++) begin
               if (i < ny) begin
                  prev = ref_bit(lb[2 * i + ((k == 0) ? 1 : 0)], prev);
                  b = prev ^ invert;
               end else begin
                  b = 1'b0;
               end
               if (k == 0) exp0.push_back({(line_idx == 0 && i == 0), b});
               else        exp1.push_back({(line_idx == 0 && i == 0), b});
            end
         end
      end
      line_idx++;
   endtask

   task automatic model_frame_end();
      if (line_idx < int'(V)) begin
         ferr = 1;
         for (int l = line_idx; l < int'(V); l++) begin
            for (int i = 0; i < int'(H); i++) begin
               exp0.push_back({(l == 0 && i == 0), 1'b0});
               exp1.push_back({(l == 0 && i == 0), 1'b0});
            end
         end
      end
      if (ferr) eerr++;
   endtask

   task automatic vsync_pulse();
      if (armed) model_frame_end();
      cam_vsync = 1'b1;
      cyc(14);
      cam_vsync = 1'b0;
      cyc(4);
      armed = 1;
      line_idx = 0;
      ferr = 0;
   endtask

   task automatic send_line(input int nby);
      model_line(nby);
      for (int i = 0; i < nby; i++) begin
         cam_href = 1'b1;
         cam_data = lb[i];
         cyc(1);
      end
      cam_href = 1'b0;
      cam_data = 8'd0;
      cyc(8);
   endtask

   task automatic set8(input logic [7:0] a, b, c, d, e, f, g, h);
      lb[0] = a; lb[1] = b; lb[2] = c; lb[3] = d;
      lb[4] = e; lb[5] = f; lb[6] = g; lb[7] = h;
   endtask

   task automatic clear_all();
      got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
      gerr0 = 0; gerr1 = 0; eerr = 0;
   endtask

   task automatic compare(input string tag);
      check({tag, " count0"}, got0.size(), exp0.size());
      check({tag, " count1"}, got1.size(), exp1.size());
      for (int i = 0; i < got0.size() && i < exp0.size(); i++)
         check($sformatf("%s px0[%0d]", tag, i), got0[i], exp0[i]);
      for (int i = 0; i < got1.size() && i < exp1.size(); i++)
         check($sformatf("%s px1[%0d]", tag, i), got1[i], exp1[i]);
      check({tag, " ferr0"}, gerr0, eerr);
      check({tag, " ferr1"}, gerr1, eerr);
      clear_all();
   endtask

   // Packs pixel bits of a stream, first pixel in the MSB.
   function automatic logic [31:0] pack_bits(input logic [1:0] q[$]);
      logic [31:0] v = 0;
      foreach (q[i]) v = (v << 1) | 32'(q[i][0]);
      return v;
   endfunction

   initial begin
      rst = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'd0;
      threshold = 8'd128; invert = 1'b0;
      cyc(3);
      check("reset pixel_valid0", pv0, 0);
      check("reset pixel_bit0", pb0, 0);
      check("reset frame_start0", fs0, 0);
      check("reset frame_error0", fe0, 0);
      check("reset pixel_valid1", pv1, 0);
      rst = 1'b0;
      cyc(2);
      vsync_pulse();

      // Nominal frame; the Y_FIRST=1 instance sees the U/V bytes as luma.
      set8(8'd10, 8'd200, 8'd250, 8'd50, 8'd10, 8'd128, 8'd250, 8'd127);
      send_line(8);
      send_line(8);
      vsync_pulse();
`ifndef THRESH_HYST_EN
      check("nominal bits0", pack_bits(got0), 32'hAA);
      check("nominal bits1", pack_bits(got1), 32'h55);
`endif
      check("nominal start0", got0.size() > 0 ? got0[0][1] : 1'b0, 1);
      compare("nominal");

      invert = 1'b1;
      send_line(8);
      send_line(8);
      vsync_pulse();
`ifndef THRESH_HYST_EN
      check("invert bits0", pack_bits(got0), 32'h55);
`endif
      compare("invert");
      invert = 1'b0;

      // Short line: 2 Y samples then padding.
      send_line(4);
      send_line(8);
      vsync_pulse();
      compare("short_line");

      // Long first line (6 Y) plus a surplus third line.
      set8(8'd0, 8'd200, 8'd0, 8'd50, 8'd0, 8'd128, 8'd0, 8'd127);
      lb[8] = 8'd0; lb[9] = 8'd255; lb[10] = 8'd0; lb[11] = 8'd255;
      send_line(12);
      send_line(8);
      send_line(8);
      vsync_pulse();
      check("long_line frame_error", gerr0, 1);
      compare("long_line");

      // Short frame (1 line), then a normal frame.
      send_line(8);
      vsync_pulse();
      compare("short_frame");
      send_line(8);
      send_line(8);
      vsync_pulse();
      compare("after_short");

`ifdef THRESH_HYST_EN
      threshold = 8'd128;
      set8(8'd0, 8'd200, 8'd0, 8'd130, 8'd0, 8'd100, 8'd0, 8'd130);
      send_line(8);
      send_line(8);
      vsync_pulse();
      check("hyst bits0", pack_bits(got0), 32'hCC);
      compare("hyst");
`endif

      // Randomized frames.
      for (int f = 0; f < 24; f++) begin
         int nl, nby;
         threshold = 8'($urandom_range(0, 255));
         invert = 1'($urandom_range(0, 1));
         nl = $urandom_range(1, int'(V));
         for (int l = 0; l < nl; l++) begin
            if (l < nl - 1 && $urandom_range(0, 3) == 0) nby = 2 * (int'(H) + $urandom_range(1, 2));
            else if ($urandom_range(0, 1) == 0) nby = 2 * int'(H);
            else nby = 2 * $urandom_range(1, int'(H));
            for (int i = 0; i < 16; i++) lb[i] = 8'($urandom_range(0, 255));
            send_line(nby);
         end
         vsync_pulse();
         compare($sformatf("rand%0d", f));
      end

      // Reset in the middle of a line.
      threshold = 8'd128; invert = 1'b0;
      set8(8'd10, 8'd200, 8'd250, 8'd50, 8'd10, 8'd128, 8'd250, 8'd127);
      for (int i = 0; i < 6; i++) begin
         cam_href = 1'b1;
         cam_data = lb[i];
         cyc(1);
      end
      rst = 1'b1;
      #1;
      check("midreset pixel_valid0", pv0, 0);
      check("midreset pixel_valid1", pv1, 0);
      cam_href = 1'b0;
      cyc(2);
      check("midreset hold0", pv0, 0);
      rst = 1'b0;
      clear_all();
      armed = 0; line_idx = 0; ferr = 0;
      cyc(2);
      vsync_pulse();
      send_line(8);
      send_line(8);
      vsync_pulse();
      check("after_reset count", got0.size(), 2 * H);
      compare("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
